// File: rtl/mmio_pkg.sv
// Shared types and constants for the CPU-to-peripheral MMIO bridge.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/mmio_bridge_if.sv
// Bridge-to-peripheral bus: one-hot request, shared latched
// address/data, per-slave ready and flattened read data.
interface mmio_bridge_if #(
  parameter int NUM_SLV = 4,
  parameter int DATA_W  = 32
);
  logic [NUM_SLV-1:0]        slv_req;
  logic                      slv_we;
  logic [31:0]               slv_addr;
  logic [DATA_W-1:0]         slv_wdata;
  logic [NUM_SLV-1:0]        slv_ready;
  logic [NUM_SLV*DATA_W-1:0] slv_rdata;

  modport master (
    output slv_req,
    output slv_we,
    output slv_addr,
    output slv_wdata,
    input  slv_ready,
    input  slv_rdata
  );

  modport slave (
    input  slv_req,
    input  slv_we,
    input  slv_addr,
    input  slv_wdata,
    output slv_ready,
    output slv_rdata
  );
endinterface

// File: rtl/mmio_decode.sv
// Address decoder: region hit, window index and one-hot slave select.
module mmio_decode
  import mmio_pkg::*;
#(
  parameter int          NUM_SLV  = 4,
  parameter logic [31:0] IO_BASE  = 32'hFFFF_F000,
  parameter int          IO_BITS  = 12,
  parameter int          WIN_BITS = 8,
  localparam int         IDX_W    = IO_BITS - WIN_BITS
) (
  input  logic [31:WIN_BITS] i_addr,
  output logic               o_hit,
  output logic [IDX_W-1:0]   o_idx,
  output logic [NUM_SLV-1:0] o_sel
);

  logic w_region;
  logic w_in_range;

  assign o_idx      = i_addr[IO_BITS-1:WIN_BITS];
  assign w_region   = (i_addr[31:IO_BITS] == IO_BASE[31:IO_BITS]);
  assign w_in_range = (32'(o_idx) < 32'(NUM_SLV));
  assign o_hit      = w_region && w_in_range;
  assign o_sel      = o_hit ? (NUM_SLV'(1) << o_idx)
                            : '0;

endmodule

// File: rtl/mmio_bridge.sv
// CPU bus to NUM_SLV MMIO windows with wait states and timeout.
// MMIO_ERR_CNT_EN adds a saturating error-response counter.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int          NUM_SLV  = 4,
  parameter int          DATA_W   = 32,
  parameter logic [31:0] IO_BASE  = 32'hFFFF_F000,
  parameter int          IO_BITS  = 12,
  parameter int          WIN_BITS = 8,
  parameter int          TIMEOUT  = 15
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
`ifdef MMIO_ERR_CNT_EN
  output logic [7:0]        err_cnt,
`endif
  mmio_bridge_if.master     slv
);

  localparam int IDX_W = IO_BITS - WIN_BITS;
  localparam int CNT_R = clog2(TIMEOUT + 1);
  localparam int CNT_W = (CNT_R < 1) ? 1 : CNT_R;

  state_t              r_state, w_state_n;
  logic [NUM_SLV-1:0]  r_req, w_req_n;
  logic [IDX_W-1:0]    r_idx, w_idx_n;
  logic                r_we, w_we_n;
  logic [31:0]         r_addr, w_addr_n;
  logic [DATA_W-1:0]   r_wdata, w_wdata_n;
  logic [CNT_W-1:0]    r_cnt, w_cnt_n;
  logic [DATA_W-1:0]   r_rdata, w_rdata_n;
  logic                r_err, w_err_n;
  logic                r_ready, w_ready_n;

  logic                w_hit;
  logic [IDX_W-1:0]    w_idx;
  logic [NUM_SLV-1:0]  w_sel;
  logic                w_sready;
  logic [DATA_W-1:0]   w_srd;

  mmio_decode #(
    .NUM_SLV  (NUM_SLV),
    .IO_BASE  (IO_BASE),
    .IO_BITS  (IO_BITS),
    .WIN_BITS (WIN_BITS)
  ) u_dec (
    .i_addr (cpu_addr[31:WIN_BITS]),
    .o_hit  (w_hit),
    .o_idx  (w_idx),
    .o_sel  (w_sel)
  );

  // r_req is one-hot, so masking isolates the selected slave's ready
  assign w_sready = |(slv.slv_ready & r_req);
  assign w_srd    = slv.slv_rdata[r_idx*DATA_W +: DATA_W];

  always_comb begin
    w_state_n = r_state;
    w_req_n   = r_req;
    w_idx_n   = r_idx;
    w_we_n    = r_we;
    w_addr_n  = r_addr;
    w_wdata_n = r_wdata;
    w_cnt_n   = r_cnt;
    w_rdata_n = r_rdata;
    w_err_n   = r_err;
    w_ready_n = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (cpu_req) begin
          w_we_n    = cpu_we;
          w_addr_n  = cpu_addr;
          w_wdata_n = cpu_wdata;
          w_cnt_n   = '0;
          if (w_hit) begin
            w_state_n = ACCESS;
            w_req_n   = w_sel;
            w_idx_n   = w_idx;
          end else begin
            w_state_n = RESP;
            w_err_n   = 1'b1;
            w_rdata_n = DATA_W'(ERR_RDATA);
            w_ready_n = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (w_sready) begin
          w_state_n = RESP;
          w_req_n   = '0;
          w_err_n   = 1'b0;
          w_rdata_n = r_we ? '0 : w_srd;
          w_ready_n = 1'b1;
        end else if (r_cnt == CNT_W'(TIMEOUT)) begin
          w_state_n = RESP;
          w_req_n   = '0;
          w_err_n   = 1'b1;
          w_rdata_n = DATA_W'(ERR_RDATA);
          w_ready_n = 1'b1;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      RESP: begin
        w_state_n = IDLE;
      end
      default: begin
        w_state_n = IDLE;
        w_req_n   = '0;
      end
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_state <= IDLE;
      r_req   <= '0;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_req   <= w_req_n;
      r_idx   <= w_idx_n;
      r_we    <= w_we_n;
      r_addr  <= w_addr_n;
      r_wdata <= w_wdata_n;
      r_cnt   <= w_cnt_n;
      r_rdata <= w_rdata_n;
      r_err   <= w_err_n;
      r_ready <= w_ready_n;
    end
  end

`ifdef MMIO_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_err_cnt <= '0;
    end else if (r_state == RESP && r_err
                 && r_err_cnt != 8'hFF) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

  assign cpu_ready     = r_ready;
  assign cpu_rdata     = r_rdata;
  assign cpu_err       = r_err;
  assign slv.slv_req   = r_req;
  assign slv.slv_we    = r_we;
  assign slv.slv_addr  = r_addr;
  assign slv.slv_wdata = r_wdata;

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed and randomized bench for mmio_bridge against a
// transaction-level model of decode, latency and response data.
module tb_mmio_bridge;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int TO = 15;

  logic          clk;
  logic          rst_n;
  logic          cpu_req;
  logic          cpu_we;
  logic [31:0]   cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ready;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_err;
`ifdef MMIO_ERR_CNT_EN
  logic [7:0]    err_cnt;
  int            m_errc;
`endif

  int checks;
  int errors;

  mmio_bridge_if #(.NUM_SLV(NS), .DATA_W(DW)) slv ();

  mmio_bridge dut (
    .cpu_clk   (clk),
    .cpu_rst_n (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ready (cpu_ready),
    .cpu_rdata (cpu_rdata),
    .cpu_err   (cpu_err),
`ifdef MMIO_ERR_CNT_EN
    .err_cnt   (err_cnt),
`endif
    .slv       (slv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // One CPU transaction; the slave answers after `waits` ACCESS cycles.
  task automatic run(input logic we,
                     input logic [31:0] addr,
                     input logic [31:0] wdata,
                     input int waits,
                     input logic [31:0] srd);
    int idx;
    bit hit;
    int e_lat, e_reqc;
    logic e_err;
    logic [31:0] e_rd;
    logic [NS-1:0] sel;
    int lat, reqc, bad;
    bit done;

    idx = int'((addr >> 8) & 32'hF);
    hit = (addr[31:12] == 20'hFFFFF) && (idx < NS);
    sel = hit ? NS'(1 << idx) : '0;
    if (!hit) begin
      e_lat = 1; e_reqc = 0;
      e_err = 1'b1; e_rd = 32'hDEAD_BEEF;
    end else if (waits <= TO) begin
      e_lat = 2 + waits; e_reqc = waits + 1;
      e_err = 1'b0; e_rd = we ? 32'h0 : srd;
    end else begin
      e_lat = TO + 2; e_reqc = TO + 1;
      e_err = 1'b1; e_rd = 32'hDEAD_BEEF;
    end

    for (int i = 0; i < NS; i++)
      slv.slv_rdata[i*DW +: DW] = $urandom;
    if (hit) slv.slv_rdata[idx*DW +: DW] = srd;
    slv.slv_ready = '0;

    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = addr;
    cpu_wdata = wdata;
    lat = 0; reqc = 0; bad = 0; done = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (cpu_ready) begin
        done = 1;
        chk("resp_noreq", 64'(slv.slv_req), 64'h0);
        cpu_req = 1'b0;
        slv.slv_ready = '0;
      end else if (slv.slv_req != '0) begin
        reqc++;
        if (slv.slv_req !== sel) bad++;
        slv.slv_ready = NS'($urandom) & ~sel;
        if (reqc - 1 == waits) slv.slv_ready |= sel;
      end else begin
        slv.slv_ready = '0;
      end
    end
    cpu_req = 1'b0;
    slv.slv_ready = '0;

    chk("latency", 64'(lat), 64'(e_lat));
    chk("req_cycles", 64'(reqc), 64'(e_reqc));
    chk("req_onehot", 64'(bad), 64'h0);
    chk("cpu_err", 64'(cpu_err), 64'(e_err));
    chk("cpu_rdata", 64'(cpu_rdata), 64'(e_rd));
    chk("slv_addr", 64'(slv.slv_addr), 64'(addr));
    chk("slv_wdata", 64'(slv.slv_wdata), 64'(wdata));
    chk("slv_we", 64'(slv.slv_we), 64'(we));

    @(negedge clk);
    chk("ready_pulse", 64'(cpu_ready), 64'h0);
    chk("rdata_hold", 64'(cpu_rdata), 64'(e_rd));
`ifdef MMIO_ERR_CNT_EN
    if (e_err && m_errc < 255) m_errc++;
    chk("err_cnt", 64'(err_cnt), 64'(m_errc));
`endif
  endtask

  initial begin
    int n;
    int guard;
    logic [31:0] a;
    int w;
    int k;

    checks = 0;
    errors = 0;
`ifdef MMIO_ERR_CNT_EN
    m_errc = 0;
`endif
    rst_n = 1'b0;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    slv.slv_ready = '0;
    slv.slv_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(cpu_ready), 64'h0);
    chk("rst_err", 64'(cpu_err), 64'h0);
    chk("rst_rdata", 64'(cpu_rdata), 64'h0);
    chk("rst_req", 64'(slv.slv_req), 64'h0);
    chk("rst_addr", 64'(slv.slv_addr), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run(1'b1, 32'hFFFF_F000, 32'h1234_5678, 0, 32'h0);
    run(1'b0, 32'hFFFF_F270, 32'h0, 3, 32'hA5A5_0003);
    run(1'b0, 32'hFFFF_F400, 32'h0, 0, 32'h0);
    run(1'b0, 32'h1000_0000, 32'h0, 0, 32'h0);
    run(1'b0, 32'hFFFF_F100, 32'h0, 100, 32'h0);
    run(1'b0, 32'hFFFF_F100, 32'h0, 15, 32'h0BAD_F00D);
    run(1'b0, 32'hFFFF_F3FC, 32'h0, 1, 32'h7777_1234);

    for (int t = 0; t < 40; t++) begin
      k = $urandom_range(0, 9);
      if (k < 6)
        a = 32'hFFFF_F000 | ($urandom_range(0, 3) << 8)
            | ($urandom & 32'hFC);
      else if (k < 8)
        a = 32'hFFFF_F000 | ($urandom_range(4, 15) << 8);
      else
        a = $urandom & 32'h7FFF_FFFF;
      w = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 18)
                                      : $urandom_range(0, 4);
      run(1'($urandom), a, $urandom, w, $urandom);
    end

`ifdef MMIO_ERR_CNT_EN
    for (int t = 0; t < 260; t++) begin
      run(1'b0, 32'hFFFF_F800, 32'h0, 0, 32'h0);
      if (t % 50 == 0)
        run(1'b0, 32'hFFFF_F200, 32'h0, 1, 32'h1111_2222);
    end
`endif

    // asynchronous reset in the second ACCESS cycle
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 32'hFFFF_F000;
    n = 0;
    guard = 0;
    while (n < 2 && guard < 10) begin
      @(negedge clk);
      guard++;
      if (slv.slv_req != '0) n++;
    end
    chk("rst_mid_reached", 64'(n), 64'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("async_req", 64'(slv.slv_req), 64'h0);
    chk("async_ready", 64'(cpu_ready), 64'h0);
    chk("async_addr", 64'(slv.slv_addr), 64'h0);
    cpu_req = 1'b0;
`ifdef MMIO_ERR_CNT_EN
    m_errc = 0;
    chk("async_errcnt", 64'(err_cnt), 64'h0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(1'b0, 32'hFFFF_F0A0, 32'h0, 0, 32'hC0DE_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
